// File: rtl/matrix_framebuf.sv
// Double-buffered 3-bit RGB frame store for a HUB75 panel driver.
// Writes and clears target the back bank; reads come from the front bank; swaps happen only on frame_sync.
module matrix_framebuf #(
    parameter int COLS = 64,
    parameter int ROWS = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [$clog2(COLS)-1:0]   wr_x,
    input  logic [$clog2(ROWS)-1:0]   wr_y,
    input  logic [2:0]                wr_rgb,
    input  logic                      clr_req,
    input  logic                      swap_req,
    input  logic                      frame_sync,
    input  logic [$clog2(COLS)-1:0]   rd_col,
    input  logic [$clog2(ROWS)-2:0]   rd_row,
    output logic [2:0]                top_rgb,
    output logic [2:0]                bot_rgb,
    output logic                      busy,
    output logic                      swap_pending,
    output logic                      front_bank,
    output logic                      swap_done
);

    localparam int XW    = $clog2(COLS);
    localparam int YW    = $clog2(ROWS);
    localparam int AW    = XW + YW;
    localparam int DEPTH = COLS * ROWS;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    logic [2:0]    mem_q [0:2*DEPTH-1];

    logic [0:0]    state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          front_q, front_d;
    logic          pend_q, pend_d;
    logic          done_q, done_d;
    logic [2:0]    top_q, top_d;
    logic [2:0]    bot_q, bot_d;

    logic          mem_we_s;
    logic [AW:0]   mem_waddr_s;
    logic [2:0]    mem_wdata_s;
    logic          do_swap_s;

    // Clear FSM and back-bank write port selection
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_we_s    = 1'b0;
        mem_waddr_s = {~front_q, wr_y, wr_x};
        mem_wdata_s = wr_rgb;
        case (state_q)
            ST_IDLE: begin
                if (clr_req) begin
                    // a write arriving with the clear request is dropped
                    state_d = ST_CLEAR;
                    cnt_d   = {AW{1'b0}};
                end else if (wr_en) begin
                    mem_we_s = 1'b1;
                end else begin
                    mem_we_s = 1'b0;
                end
            end
            ST_CLEAR: begin
                mem_we_s    = 1'b1;
                mem_waddr_s = {~front_q, cnt_q};
                mem_wdata_s = 3'b000;
                if (cnt_q == AW'(DEPTH - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = {AW{1'b0}};
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {AW{1'b0}};
            end
        endcase
    end

    // Swap arbitration: only at a frame boundary while the clear engine is idle
    always_comb begin
        do_swap_s = frame_sync && (pend_q || swap_req) && (state_q == ST_IDLE);
        done_d    = do_swap_s;
        if (do_swap_s) begin
            front_d = ~front_q;
            pend_d  = 1'b0;
        end else if (swap_req) begin
            front_d = front_q;
            pend_d  = 1'b1;
        end else begin
            front_d = front_q;
            pend_d  = pend_q;
        end
    end

    // Front-bank read of the top and bottom half pixel pair
    always_comb begin
        top_d = mem_q[{front_q, 1'b0, rd_row, rd_col}];
        bot_d = mem_q[{front_q, 1'b1, rd_row, rd_col}];
    end

    // Pixel storage has no reset; contents are undefined until written or cleared
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[mem_waddr_s] <= mem_wdata_s;
        end
    end

    // Control and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= {AW{1'b0}};
            front_q <= 1'b0;
            pend_q  <= 1'b0;
            done_q  <= 1'b0;
            top_q   <= 3'b000;
            bot_q   <= 3'b000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            front_q <= front_d;
            pend_q  <= pend_d;
            done_q  <= done_d;
            top_q   <= top_d;
            bot_q   <= bot_d;
        end
    end

    assign top_rgb      = top_q;
    assign bot_rgb      = bot_q;
    assign busy         = (state_q == ST_CLEAR);
    assign swap_pending = pend_q;
    assign front_bank   = front_q;
    assign swap_done    = done_q;

endmodule

// File: tb/tb_matrix_framebuf.sv
// Scoreboard bench for matrix_framebuf: reads are predicted from a bank model
// when the address is driven and compared when the registered pixels appear.
module tb_matrix_framebuf;

    localparam int COLS  = 64;
    localparam int ROWS  = 32;
    localparam int DEPTH = COLS * ROWS;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [5:0] wr_x = 6'd0;
    logic [4:0] wr_y = 5'd0;
    logic [2:0] wr_rgb = 3'b000;
    logic       clr_req = 1'b0;
    logic       swap_req = 1'b0;
    logic       frame_sync = 1'b0;
    logic [5:0] rd_col = 6'd0;
    logic [3:0] rd_row = 4'd0;
    logic [2:0] top_rgb, bot_rgb;
    logic       busy, swap_pending, front_bank, swap_done;

    matrix_framebuf #(.COLS(COLS), .ROWS(ROWS)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_rgb(wr_rgb),
        .clr_req(clr_req), .swap_req(swap_req), .frame_sync(frame_sync),
        .rd_col(rd_col), .rd_row(rd_row), .top_rgb(top_rgb), .bot_rgb(bot_rgb),
        .busy(busy), .swap_pending(swap_pending), .front_bank(front_bank), .swap_done(swap_done)
    );

    always #5 clk = ~clk;

    logic [2:0] m_mem [0:2*DEPTH-1];
    logic       m_front;
    logic       m_pend;
    int         m_busy;
    logic [5:0] exp_q [$];
    bit         chk_rd;
    int         n_tests;
    int         n_fail;

    task automatic strobes_off();
        wr_en = 1'b0; clr_req = 1'b0; swap_req = 1'b0; frame_sync = 1'b0;
    endtask

    // One clock: predict with the model, advance it, then compare the read data
    task automatic cycle();
        logic [5:0] e;
        logic sw;
        if (chk_rd)
            exp_q.push_back({m_mem[{m_front, 1'b0, rd_row, rd_col}], m_mem[{m_front, 1'b1, rd_row, rd_col}]});
        sw = frame_sync && (m_pend || swap_req) && (m_busy == 0);
        if (m_busy == 0 && wr_en && !clr_req) m_mem[{~m_front, wr_y, wr_x}] = wr_rgb;
        if (m_busy == 0 && clr_req) begin
            for (int i = 0; i < DEPTH; i++) m_mem[{~m_front, 11'(i)}] = 3'b000;
            m_busy = DEPTH;
        end else if (m_busy != 0) begin
            m_busy--;
        end
        if (sw) begin
            m_front = ~m_front;
            m_pend  = 1'b0;
        end else if (swap_req) begin
            m_pend = 1'b1;
        end
        @(posedge clk); #1;
        if (chk_rd) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL rd_scoreboard: queue empty, required one entry");
            end else begin
                e = exp_q.pop_front();
                if ({top_rgb, bot_rgb} !== e) begin
                    n_fail++;
                    $display("FAIL rd_data: got top=%b bot=%b, required top=%b bot=%b",
                             top_rgb, bot_rgb, e[5:3], e[2:0]);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({top_rgb, bot_rgb, busy, swap_pending, front_bank, swap_done} !== 10'b0) begin
            n_fail++;
            $display("FAIL reset_state: got %b, required %b",
                     {top_rgb, bot_rgb, busy, swap_pending, front_bank, swap_done}, 10'b0);
        end
        rst = 1'b0;
        m_front = 1'b0; m_pend = 1'b0; m_busy = 0;
    endtask

    task automatic test_clear();
        int n;
        clr_req = 1'b1;
        cycle();
        strobes_off();
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_busy_rise: got %b, required 1", busy);
        end
        n = 0;
        while (busy === 1'b1 && n < 3000) begin
            n++;
            cycle();
        end
        n_tests++;
        if (n != DEPTH) begin
            n_fail++;
            $display("FAIL clear_busy_len: got %0d cycles, required %0d", n, DEPTH);
        end
    endtask

    task automatic test_simultaneous();
        logic f0;
        f0 = m_front;
        swap_req = 1'b1; frame_sync = 1'b1;
        cycle();
        strobes_off();
        n_tests++;
        if ({front_bank, swap_pending, swap_done} !== {~f0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL simul_swap_edge: got f/p/d=%b, required %b",
                     {front_bank, swap_pending, swap_done}, {~f0, 1'b0, 1'b1});
        end
        cycle();
        n_tests++;
        if ({front_bank, swap_pending, swap_done} !== {~f0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL simul_swap_after: got f/p/d=%b, required %b",
                     {front_bank, swap_pending, swap_done}, {~f0, 1'b0, 1'b0});
        end
    endtask

    task automatic test_clear_draw();
        int ndone;
        wr_en = 1'b1; wr_x = 6'd5; wr_y = 5'd3; wr_rgb = 3'b100;
        cycle();
        wr_y = 5'd19; wr_rgb = 3'b010;
        cycle();
        wr_en = 1'b0;
        swap_req = 1'b1;
        cycle();
        swap_req = 1'b0;
        n_tests++;
        if (swap_pending !== 1'b1) begin
            n_fail++;
            $display("FAIL draw_pending: got %b, required 1", swap_pending);
        end
        repeat (5) cycle();
        rd_col = 6'd5; rd_row = 4'd3; frame_sync = 1'b1;
        cycle();
        frame_sync = 1'b0;
        ndone = int'(swap_done);
        n_tests++;
        if ({top_rgb, bot_rgb} !== 6'b000_000) begin
            n_fail++;
            $display("FAIL draw_old_bank: got %b/%b, required 000/000", top_rgb, bot_rgb);
        end
        cycle();
        ndone += int'(swap_done);
        n_tests++;
        if ({top_rgb, bot_rgb} !== 6'b100_010) begin
            n_fail++;
            $display("FAIL draw_new_bank: got %b/%b, required 100/010", top_rgb, bot_rgb);
        end
        repeat (3) begin
            cycle();
            ndone += int'(swap_done);
        end
        n_tests++;
        if (ndone != 1) begin
            n_fail++;
            $display("FAIL draw_swap_done: got %0d pulses, required 1", ndone);
        end
    endtask

    task automatic test_deferred();
        logic f0;
        f0 = m_front;
        swap_req = 1'b1;
        cycle();
        swap_req = 1'b0;
        repeat (500) cycle();
        n_tests++;
        if ({swap_pending, front_bank} !== {1'b1, f0}) begin
            n_fail++;
            $display("FAIL deferred_hold: got p/f=%b, required %b", {swap_pending, front_bank}, {1'b1, f0});
        end
        frame_sync = 1'b1;
        cycle();
        frame_sync = 1'b0;
        n_tests++;
        if ({swap_pending, front_bank} !== {1'b0, ~f0}) begin
            n_fail++;
            $display("FAIL deferred_exec: got p/f=%b, required %b", {swap_pending, front_bank}, {1'b0, ~f0});
        end
    endtask

    task automatic test_swap_during_clear();
        logic f0;
        int n;
        f0 = m_front;
        clr_req = 1'b1;
        cycle();
        strobes_off();
        repeat (99) cycle();
        swap_req = 1'b1; frame_sync = 1'b1;
        cycle();
        strobes_off();
        n_tests++;
        if ({busy, swap_pending, front_bank} !== {1'b1, 1'b1, f0}) begin
            n_fail++;
            $display("FAIL clrswap_blocked: got b/p/f=%b, required %b",
                     {busy, swap_pending, front_bank}, {1'b1, 1'b1, f0});
        end
        repeat (100) cycle();
        // (0,0) was already cleared; this write and clr_req must be ignored
        wr_en = 1'b1; wr_x = 6'd0; wr_y = 5'd0; wr_rgb = 3'b111; clr_req = 1'b1;
        cycle();
        strobes_off();
        n = 0;
        while (busy === 1'b1 && n < 3000) begin
            n++;
            cycle();
        end
        n_tests++;
        if ({busy, swap_pending, front_bank} !== {1'b0, 1'b1, f0}) begin
            n_fail++;
            $display("FAIL clrswap_after_clear: got b/p/f=%b, required %b",
                     {busy, swap_pending, front_bank}, {1'b0, 1'b1, f0});
        end
        rd_col = 6'd0; rd_row = 4'd0; frame_sync = 1'b1;
        cycle();
        frame_sync = 1'b0;
        n_tests++;
        if ({swap_pending, front_bank} !== {1'b0, ~f0}) begin
            n_fail++;
            $display("FAIL clrswap_exec: got p/f=%b, required %b", {swap_pending, front_bank}, {1'b0, ~f0});
        end
        cycle();
        n_tests++;
        if (top_rgb !== 3'b000) begin
            n_fail++;
            $display("FAIL clr_write_dropped: got %b, required 000", top_rgb);
        end
    endtask

    task automatic test_write_isolation();
        rd_col = 6'd0; rd_row = 4'd0;
        wr_en = 1'b1; wr_x = 6'd0; wr_y = 5'd0; wr_rgb = 3'b111;
        cycle();
        wr_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_tests++;
            if (top_rgb !== 3'b000) begin
                n_fail++;
                $display("FAIL isolation_front: got %b, required 000", top_rgb);
            end
        end
        swap_req = 1'b1; frame_sync = 1'b1;
        cycle();
        strobes_off();
        cycle();
        n_tests++;
        if (top_rgb !== 3'b111) begin
            n_fail++;
            $display("FAIL isolation_swapped: got %b, required 111", top_rgb);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 400; i++) begin
            wr_en      = 1'($urandom_range(0, 1));
            wr_x       = 6'($urandom_range(0, 63));
            wr_y       = 5'($urandom_range(0, 31));
            wr_rgb     = 3'($urandom_range(0, 7));
            rd_col     = 6'($urandom_range(0, 63));
            rd_row     = 4'($urandom_range(0, 15));
            swap_req   = ($urandom_range(0, 15) == 0);
            frame_sync = (i % 40 == 39);
            cycle();
        end
        strobes_off();
        cycle();
        n_tests++;
        if ({front_bank, swap_pending} !== {m_front, m_pend}) begin
            n_fail++;
            $display("FAIL b2b_status: got f/p=%b, required %b", {front_bank, swap_pending}, {m_front, m_pend});
        end
    endtask

    task automatic test_reset_midrun();
        if (m_front == 1'b0) begin
            swap_req = 1'b1; frame_sync = 1'b1;
            cycle();
            strobes_off();
        end
        rd_col = 6'd5; rd_row = 4'd3;
        clr_req = 1'b1;
        cycle();
        clr_req = 1'b0; swap_req = 1'b1;
        cycle();
        swap_req = 1'b0;
        repeat (10) cycle();
        n_tests++;
        if ({busy, swap_pending, front_bank} !== 3'b111) begin
            n_fail++;
            $display("FAIL midrun_pre: got b/p/f=%b, required 111", {busy, swap_pending, front_bank});
        end
        chk_rd = 1'b0;
        exp_q.delete();
        #3 rst = 1'b1;
        #1;
        n_tests++;
        if ({top_rgb, bot_rgb, busy, swap_pending, front_bank, swap_done} !== 10'b0) begin
            n_fail++;
            $display("FAIL midrun_async_reset: got %b, required %b",
                     {top_rgb, bot_rgb, busy, swap_pending, front_bank, swap_done}, 10'b0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        m_front = 1'b0; m_pend = 1'b0; m_busy = 0;
        cycle();
        n_tests++;
        if ({busy, swap_pending, front_bank} !== 3'b000) begin
            n_fail++;
            $display("FAIL midrun_after: got b/p/f=%b, required 000", {busy, swap_pending, front_bank});
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        chk_rd  = 1'b0;
        for (int i = 0; i < 2*DEPTH; i++) m_mem[i] = 3'bxxx;
        test_reset();
        test_clear();
        test_simultaneous();
        test_clear();
        chk_rd = 1'b1;
        test_clear_draw();
        test_deferred();
        test_swap_during_clear();
        test_write_isolation();
        test_back_to_back();
        test_reset_midrun();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
